// File: rtl/uart_pkg.sv
// Shared UART timing constants.
// Divisors assume a 50 MHz project clock.
package uart_pkg;

  localparam int unsigned UART_CLK_HZ    = 50_000_000;
  localparam int          UART_DIV_WIDTH = 16;
  localparam int          UART_OVS       = 16;

  // Rounded clocks per oversample tick for a given baud rate.
  function automatic int unsigned calc_div(
    input int unsigned hz,
    input int unsigned baud,
    input int unsigned ovs
  );
    return (hz + (baud * ovs) / 2) / (baud * ovs);
  endfunction

  localparam int UART_DIV_9600   = calc_div(UART_CLK_HZ, 9600, UART_OVS);
  localparam int UART_DIV_115200 = calc_div(UART_CLK_HZ, 115200, UART_OVS);

endpackage

// File: rtl/baud_tick_gen_if.sv
// Control/status bundle of the baud tick generator.
// master drives control, slave is the generator.
interface baud_tick_gen_if #(
  parameter int DIV_WIDTH = 16,
  parameter int OVS       = 16
);
  logic                       enable;
  logic                       sync;
  logic [DIV_WIDTH-1:0]       div_in;
  logic                       div_load;
  logic                       ovs_tick;
  logic [$clog2(OVS)-1:0]     ovs_count;
  logic                       mid_bit;
  logic                       end_bit;
  logic [DIV_WIDTH-1:0]       div_active;
  logic                       div_pending;

  modport master (
    output enable, sync, div_in, div_load,
    input  ovs_tick, ovs_count, mid_bit,
    input  end_bit, div_active, div_pending
  );

  modport slave (
    input  enable, sync, div_in, div_load,
    output ovs_tick, ovs_count, mid_bit,
    output end_bit, div_active, div_pending
  );
endinterface

// File: rtl/baud_prescaler.sv
// Mod-N counter with runtime N, enable,
// synchronous clear and terminal-count pulse.
module baud_prescaler #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_div,
  output logic         o_tc
);
  logic [W-1:0] r_cnt;
  logic         w_last;

  // >= also catches a count left above a divisor that shrank while idle
  assign w_last = (r_cnt >= (i_div - W'(1)));
  assign o_tc   = i_en & ~i_clr & w_last;

  // counter: clear wins, wraps on terminal count, holds when disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_en)
      r_cnt <= o_tc ? '0 : r_cnt + W'(1);
  end
endmodule

// File: rtl/baud_tick_gen.sv
// Programmable baud timing: prescaler + sub-bit
// counter, bit-boundary divisor updates, resync.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH   = UART_DIV_WIDTH,
  parameter int OVS         = UART_OVS,
  parameter int DEFAULT_DIV = UART_DIV_115200
) (
  input  logic             clk,
  input  logic             rst,
  baud_tick_gen_if.slave   bus
);
  localparam int CW = $clog2(OVS);

  logic [CW-1:0]        r_ovs_cnt;
  logic [DIV_WIDTH-1:0] r_div_active;
  logic [DIV_WIDTH-1:0] r_div_next;
  logic                 r_div_pending;

  logic                 w_ovs_tick;
  logic                 w_mid_bit;
  logic                 w_end_bit;
  logic                 w_boundary;
  logic [DIV_WIDTH-1:0] w_load_val;

  baud_prescaler #(
    .W (DIV_WIDTH)
  ) u_pre (
    .clk   (clk),
    .rst   (rst),
    .i_en  (bus.enable),
    .i_clr (bus.sync),
    .i_div (r_div_active),
    .o_tc  (w_ovs_tick)
  );

  assign w_end_bit = w_ovs_tick & (r_ovs_cnt == CW'(OVS - 1));
  assign w_mid_bit = w_ovs_tick & (r_ovs_cnt == CW'(OVS / 2 - 1));

  // divisor of zero would stall the prescaler, so it becomes one
  assign w_load_val = (bus.div_in == '0) ? DIV_WIDTH'(1) : bus.div_in;

  // points where a divisor swap cannot split a bit
  assign w_boundary = w_end_bit | bus.sync | ~bus.enable;

  // sub-bit index: resync clears, advances on each oversample tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_ovs_cnt <= '0;
    else if (bus.sync)
      r_ovs_cnt <= '0;
    else if (w_ovs_tick)
      r_ovs_cnt <= r_ovs_cnt + CW'(1);
  end

  // divisor staging: capture on load, commit only on a boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_active  <= DIV_WIDTH'(DEFAULT_DIV);
      r_div_next    <= '0;
      r_div_pending <= 1'b0;
    end else begin
      if (bus.div_load)
        r_div_next <= w_load_val;
      if (w_boundary) begin
        r_div_pending <= 1'b0;
        if (bus.div_load)
          r_div_active <= w_load_val;
        else if (r_div_pending)
          r_div_active <= r_div_next;
      end else if (bus.div_load) begin
        r_div_pending <= 1'b1;
      end
    end
  end

  assign bus.ovs_tick    = w_ovs_tick;
  assign bus.ovs_count   = r_ovs_cnt;
  assign bus.mid_bit     = w_mid_bit;
  assign bus.end_bit     = w_end_bit;
  assign bus.div_active  = r_div_active;
  assign bus.div_pending = r_div_pending;
endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen with
// DEFAULT_DIV=4, OVS=4 (16-clock bit).
module tb_baud_tick_gen;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  baud_tick_gen_if #(.DIV_WIDTH(16), .OVS(4)) bus ();

  baud_tick_gen #(
    .DIV_WIDTH   (16),
    .OVS         (4),
    .DEFAULT_DIV (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // leaves the bench at a negedge, i.e. start of cycle 0
  task automatic do_reset();
    bus.enable   = 1'b0;
    bus.sync     = 1'b0;
    bus.div_load = 1'b0;
    bus.div_in   = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    bus.enable = 1'b1;
    #1;
    n_tests++;
    if (bus.ovs_count !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_ovs_count got %0d exp 0", bus.ovs_count);
    end
    n_tests++;
    if (bus.div_active !== 16'd4) begin
      n_fail++;
      $display("FAIL rst_div_active got %0d exp 4", bus.div_active);
    end
    n_tests++;
    if (bus.div_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_div_pending got %b exp 0", bus.div_pending);
    end
    n_tests++;
    if ({bus.ovs_tick, bus.mid_bit, bus.end_bit} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_pulses got %b%b%b exp 000",
               bus.ovs_tick, bus.mid_bit, bus.end_bit);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_default();
    logic [31:0] tk, mb, eb;
    tk = '0; mb = '0; eb = '0;
    do_reset();
    for (int c = 0; c < 32; c++) begin
      bus.enable = 1'b1;
      #1;
      tk[c] = bus.ovs_tick;
      mb[c] = bus.mid_bit;
      eb[c] = bus.end_bit;
      @(negedge clk);
    end
    n_tests++;
    if (tk !== 32'h8888_8888) begin
      n_fail++;
      $display("FAIL default_tick got %h exp 88888888", tk);
    end
    n_tests++;
    if (mb !== 32'h0080_0080) begin
      n_fail++;
      $display("FAIL default_mid got %h exp 00800080", mb);
    end
    n_tests++;
    if (eb !== 32'h8000_8000) begin
      n_fail++;
      $display("FAIL default_end got %h exp 80008000", eb);
    end
  endtask

  task automatic test_div_update();
    logic [31:0] tk, eb, pb;
    logic [15:0] a15, a16;
    tk = '0; eb = '0; pb = '0; a15 = '0; a16 = '0;
    do_reset();
    for (int c = 0; c < 28; c++) begin
      bus.enable   = 1'b1;
      bus.div_in   = 16'd2;
      bus.div_load = (c == 5);
      #1;
      tk[c] = bus.ovs_tick;
      eb[c] = bus.end_bit;
      pb[c] = bus.div_pending;
      if (c == 15) a15 = bus.div_active;
      if (c == 16) a16 = bus.div_active;
      @(negedge clk);
    end
    bus.div_load = 1'b0;
    n_tests++;
    if (pb !== 32'h0000_FFC0) begin
      n_fail++;
      $display("FAIL upd_pending got %h exp 0000ffc0", pb);
    end
    n_tests++;
    if (eb !== 32'h0080_8000) begin
      n_fail++;
      $display("FAIL upd_end got %h exp 00808000", eb);
    end
    n_tests++;
    if (tk !== 32'h0AAA_8888) begin
      n_fail++;
      $display("FAIL upd_tick got %h exp 0aaa8888", tk);
    end
    n_tests++;
    if (a15 !== 16'd4 || a16 !== 16'd2) begin
      n_fail++;
      $display("FAIL upd_active got %0d/%0d exp 4/2", a15, a16);
    end
  endtask

  task automatic test_sync();
    logic [31:0] tk, mb, eb;
    logic [1:0]  o9, o10;
    tk = '0; mb = '0; eb = '0; o9 = '0; o10 = '1;
    do_reset();
    for (int c = 0; c < 32; c++) begin
      bus.enable = 1'b1;
      bus.sync   = (c == 9);
      #1;
      tk[c] = bus.ovs_tick;
      mb[c] = bus.mid_bit;
      eb[c] = bus.end_bit;
      if (c == 9)  o9  = bus.ovs_count;
      if (c == 10) o10 = bus.ovs_count;
      @(negedge clk);
    end
    bus.sync = 1'b0;
    n_tests++;
    if (o9 !== 2'd2 || o10 !== 2'd0) begin
      n_fail++;
      $display("FAIL sync_count got %0d/%0d exp 2/0", o9, o10);
    end
    n_tests++;
    if (tk !== 32'h2222_2088) begin
      n_fail++;
      $display("FAIL sync_tick got %h exp 22222088", tk);
    end
    n_tests++;
    if (eb !== 32'h0200_0000) begin
      n_fail++;
      $display("FAIL sync_end got %h exp 02000000", eb);
    end
    n_tests++;
    if (mb !== 32'h0002_0080) begin
      n_fail++;
      $display("FAIL sync_mid got %h exp 00020080", mb);
    end
  endtask

  task automatic test_sync_on_tick();
    logic [15:0] tk;
    tk = '0;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      bus.enable = 1'b1;
      bus.sync   = (c == 3);
      #1;
      tk[c] = bus.ovs_tick;
      @(negedge clk);
    end
    bus.sync = 1'b0;
    n_tests++;
    if (tk !== 16'h8880) begin
      n_fail++;
      $display("FAIL sync_suppress got %h exp 8880", tk);
    end
  endtask

  task automatic test_div_zero();
    logic [15:0] tk, mb, eb;
    logic        p1;
    logic [15:0] a2;
    tk = '0; mb = '0; eb = '0; p1 = 1'b0; a2 = '0;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      bus.enable   = 1'b1;
      bus.div_in   = 16'd0;
      bus.div_load = (c == 0);
      bus.sync     = (c == 1);
      #1;
      tk[c] = bus.ovs_tick;
      mb[c] = bus.mid_bit;
      eb[c] = bus.end_bit;
      if (c == 1) p1 = bus.div_pending;
      if (c == 2) a2 = bus.div_active;
      @(negedge clk);
    end
    bus.div_load = 1'b0;
    bus.sync     = 1'b0;
    n_tests++;
    if (p1 !== 1'b1 || a2 !== 16'd1) begin
      n_fail++;
      $display("FAIL zero_clamp got pend=%b act=%0d exp 1/1", p1, a2);
    end
    n_tests++;
    if (tk !== 16'hFFFC) begin
      n_fail++;
      $display("FAIL zero_tick got %h exp fffc", tk);
    end
    n_tests++;
    if (eb !== 16'h2220 || mb !== 16'h8888) begin
      n_fail++;
      $display("FAIL zero_end_mid got %h/%h exp 2220/8888", eb, mb);
    end
  endtask

  task automatic test_enable_gap();
    logic [31:0] tk, mb, eb;
    logic [1:0]  o6, o11;
    tk = '0; mb = '0; eb = '0; o6 = '0; o11 = '0;
    do_reset();
    for (int c = 0; c < 24; c++) begin
      bus.enable = !(c >= 6 && c <= 11);
      #1;
      tk[c] = bus.ovs_tick;
      mb[c] = bus.mid_bit;
      eb[c] = bus.end_bit;
      if (c == 6)  o6  = bus.ovs_count;
      if (c == 11) o11 = bus.ovs_count;
      @(negedge clk);
    end
    n_tests++;
    if (o6 !== 2'd1 || o11 !== 2'd1) begin
      n_fail++;
      $display("FAIL gap_hold got %0d/%0d exp 1/1", o6, o11);
    end
    n_tests++;
    if (tk !== 32'h0022_2008) begin
      n_fail++;
      $display("FAIL gap_tick got %h exp 00222008", tk);
    end
    n_tests++;
    if (eb !== 32'h0020_0000 || mb !== 32'h0000_2000) begin
      n_fail++;
      $display("FAIL gap_end_mid got %h/%h exp 00200000/00002000", eb, mb);
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] tk, eb;
    tk = '0; eb = '0;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      bus.enable   = 1'b1;
      bus.div_in   = 16'd2;
      bus.div_load = (c == 5);
      @(negedge clk);
    end
    bus.div_load = 1'b0;
    #1;
    n_tests++;
    if (bus.div_pending !== 1'b1 || bus.ovs_count !== 2'd2) begin
      n_fail++;
      $display("FAIL arst_pre got pend=%b cnt=%0d exp 1/2",
               bus.div_pending, bus.ovs_count);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.ovs_count !== 2'd0 || bus.div_active !== 16'd4 ||
        bus.div_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_clear got cnt=%0d act=%0d pend=%b exp 0/4/0",
               bus.ovs_count, bus.div_active, bus.div_pending);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 16; c++) begin
      bus.enable = 1'b1;
      #1;
      tk[c] = bus.ovs_tick;
      eb[c] = bus.end_bit;
      @(negedge clk);
    end
    n_tests++;
    if (tk !== 16'h8888 || eb !== 16'h8000) begin
      n_fail++;
      $display("FAIL arst_restart got %h/%h exp 8888/8000", tk, eb);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a15, a16, a28;
    logic        p15, p28, e27;
    a15 = '0; a16 = '0; a28 = '0;
    p15 = 1'b0; p28 = 1'b1; e27 = 1'b0;
    do_reset();
    for (int c = 0; c < 29; c++) begin
      bus.enable   = 1'b1;
      bus.div_load = (c == 2 || c == 4 || c == 27);
      bus.div_in   = (c == 2) ? 16'd2 : (c == 4) ? 16'd3 : 16'd5;
      #1;
      if (c == 15) begin
        a15 = bus.div_active;
        p15 = bus.div_pending;
      end
      if (c == 16) a16 = bus.div_active;
      if (c == 27) e27 = bus.end_bit;
      if (c == 28) begin
        a28 = bus.div_active;
        p28 = bus.div_pending;
      end
      @(negedge clk);
    end
    bus.div_load = 1'b0;
    n_tests++;
    if (a15 !== 16'd4 || p15 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_hold got act=%0d pend=%b exp 4/1", a15, p15);
    end
    n_tests++;
    if (a16 !== 16'd3) begin
      n_fail++;
      $display("FAIL b2b_last_wins got %0d exp 3", a16);
    end
    n_tests++;
    if (e27 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_end27 got %b exp 1", e27);
    end
    n_tests++;
    if (a28 !== 16'd5 || p28 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_direct got act=%0d pend=%b exp 5/0", a28, p28);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    test_reset();
    test_default();
    test_div_update();
    test_sync();
    test_sync_on_tick();
    test_div_zero();
    test_enable_gap();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
